// File: rtl/sl3p_deskew_ctrl_if.sv
// sl3p_deskew_ctrl_if: deskew bundle; word_locked/am_ping into the controller, fallback_req/deskew_locked/skew_err/fallback_cnt out of it
interface sl3p_deskew_ctrl_if #(parameter int LANES = 2);
  logic             word_locked;
  logic [LANES-1:0] am_ping;
  logic [LANES-1:0] fallback_req;
  logic             deskew_locked;
  logic             skew_err;
  logic [7:0]       fallback_cnt;
  modport master (output word_locked, am_ping, input fallback_req, deskew_locked, skew_err, fallback_cnt);
  modport slave (input word_locked, am_ping, output fallback_req, deskew_locked, skew_err, fallback_cnt);
endinterface

// File: rtl/sl3p_deskew_ctrl.sv
// sl3p_deskew_ctrl: cross-lane marker deskew; clk/srst plus bus (word_locked, am_ping in; fallback_req, deskew_locked, skew_err, fallback_cnt out)
module sl3p_deskew_ctrl #(
  parameter int LANES         = 2,
  parameter int MAX_SKEW      = 7,
  parameter int SETTLE_CYCLES = 15,
  parameter int LOCK_COUNT    = 4,
  parameter int MISS_LIMIT    = 3,
  parameter int TIMEOUT_BITS  = 16
) (
  input logic clk,
  input logic srst,
  sl3p_deskew_ctrl_if.slave bus
);
  localparam int KW = $clog2(MAX_SKEW + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int XW = $clog2(MISS_LIMIT + 1);
  localparam logic [KW-1:0] SKEW_END = KW'(MAX_SKEW);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYCLES);
  localparam logic [MW-1:0] MATCH_END = MW'(LOCK_COUNT);
  localparam logic [XW-1:0] MISS_END = XW'(MISS_LIMIT);
  typedef enum logic [2:0] {IDLE, HUNT, GATHER, SETTLE, LOCKED} state_t;
  state_t st, st_n;
  logic [LANES-1:0] first_m, first_n, seen_m, seen_n, seen_or, fb, fb_n;
  logic [KW-1:0] skew, skew_n;
  logic [SW-1:0] settle, settle_n;
  logic [MW-1:0] match, match_n;
  logic [XW-1:0] miss, miss_n;
  logic [TIMEOUT_BITS-1:0] wd, wd_n;
  logic [7:0] fcnt, fcnt_n;
  logic lock, lock_n, err, err_n, bad, all_ping, any_ping;
  assign all_ping = &bus.am_ping;
  assign any_ping = |bus.am_ping;
  assign seen_or = seen_m | bus.am_ping;
  assign bus.fallback_req = fb;
  assign bus.deskew_locked = lock;
  assign bus.skew_err = err;
  assign bus.fallback_cnt = fcnt;
  always_ff @(posedge clk) begin
    if (srst) begin
      st <= IDLE;
      first_m <= '0;
      seen_m <= '0;
      skew <= '0;
      settle <= '0;
      match <= '0;
      miss <= '0;
      wd <= '0;
      fb <= '0;
      err <= 1'b0;
      lock <= 1'b0;
      fcnt <= '0;
    end else begin
      st <= st_n;
      first_m <= first_n;
      seen_m <= seen_n;
      skew <= skew_n;
      settle <= settle_n;
      match <= match_n;
      miss <= miss_n;
      wd <= wd_n;
      fb <= fb_n;
      err <= err_n;
      lock <= lock_n;
      fcnt <= fcnt_n;
    end
  end
  always_comb begin
    st_n = st;
    first_n = first_m;
    seen_n = seen_m;
    skew_n = skew;
    settle_n = settle;
    match_n = match;
    miss_n = miss;
    wd_n = wd;
    fb_n = '0;
    err_n = 1'b0;
    lock_n = lock;
    fcnt_n = fcnt;
    bad = 1'b0;
    if (!bus.word_locked) begin
      st_n = IDLE;
      first_n = '0;
      seen_n = '0;
      skew_n = '0;
      settle_n = '0;
      match_n = '0;
      miss_n = '0;
      wd_n = '0;
      lock_n = 1'b0;
    end else begin
      case (st)
        IDLE: st_n = HUNT;
        HUNT: begin
          if (all_ping) begin
            match_n = match + 1'b1;
            if (match_n == MATCH_END) begin
              st_n = LOCKED;
              lock_n = 1'b1;
              miss_n = '0;
              wd_n = '0;
            end
          end else if (any_ping) begin
            first_n = bus.am_ping;
            seen_n = bus.am_ping;
            skew_n = '0;
            st_n = GATHER;
          end
        end
        GATHER: begin
          seen_n = seen_or;
          skew_n = skew + 1'b1;
          if (&seen_or) begin
            fb_n = first_m;
            fcnt_n = fcnt + {7'd0, ~&fcnt};
            match_n = '0;
            settle_n = '0;
            st_n = SETTLE;
          end else if (skew_n == SKEW_END) begin
            err_n = 1'b1;
            match_n = '0;
            st_n = HUNT;
          end
        end
        SETTLE: begin
          settle_n = settle + 1'b1;
          st_n = settle_n == SETTLE_END ? HUNT : SETTLE;
        end
        LOCKED: begin
          // partial pings hold the watchdog; only silent cycles advance it
          wd_n = all_ping ? '0 : any_ping ? wd : wd + 1'b1;
          bad = !all_ping && (any_ping || &wd_n);
          wd_n = &wd_n ? '0 : wd_n;
          miss_n = all_ping ? '0 : bad ? miss + 1'b1 : miss;
          err_n = bad;
          if (miss_n == MISS_END) begin
            st_n = HUNT;
            lock_n = 1'b0;
            match_n = '0;
            miss_n = '0;
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sl3p_deskew_ctrl.sv
// tb_sl3p_deskew_ctrl: directed and randomized lane-marker streams checked cycle by cycle against a reference model
module tb_sl3p_deskew_ctrl;
  localparam int WD = 6;
  localparam int TMO = (1 << WD) - 1;
  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;
  sl3p_deskew_ctrl_if bus ();
  sl3p_deskew_ctrl #(.TIMEOUT_BITS(WD)) dut (.clk(clk), .srst(srst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  typedef enum {M_IDLE, M_HUNT, M_GATHER, M_SETTLE, M_LOCKED} mph_t;
  mph_t ph = M_IDLE;
  int first_p, seen_p, age, wait_n, good, bad_n, quiet;
  int e_fb = 0, e_err = 0, e_lock = 0, e_cnt = 0;
  task automatic ref_step(input bit r, input bit wl, input int p);
    bit bad;
    e_fb = 0;
    e_err = 0;
    if (r) begin
      ph = M_IDLE; good = 0; bad_n = 0; quiet = 0; e_lock = 0; e_cnt = 0;
    end else if (!wl) begin
      ph = M_IDLE; good = 0; bad_n = 0; quiet = 0; e_lock = 0;
    end else begin
      case (ph)
        M_IDLE: ph = M_HUNT;
        M_HUNT: begin
          if (p == 3) begin
            good++;
            if (good == 4) begin ph = M_LOCKED; e_lock = 1; bad_n = 0; quiet = 0; end
          end else if (p != 0) begin
            first_p = p; seen_p = p; age = 0; ph = M_GATHER;
          end
        end
        M_GATHER: begin
          seen_p = seen_p | p;
          age++;
          if (seen_p == 3) begin
            e_fb = first_p;
            if (e_cnt < 255) e_cnt++;
            good = 0; wait_n = 0; ph = M_SETTLE;
          end else if (age == 7) begin
            e_err = 1; good = 0; ph = M_HUNT;
          end
        end
        M_SETTLE: begin
          wait_n++;
          if (wait_n == 15) ph = M_HUNT;
        end
        M_LOCKED: begin
          if (p == 3) begin
            bad_n = 0; quiet = 0;
          end else begin
            bad = (p != 0);
            if (p == 0) begin
              quiet++;
              if (quiet == TMO) begin bad = 1; quiet = 0; end
            end
            if (bad) begin
              e_err = 1;
              bad_n++;
              if (bad_n == 3) begin ph = M_HUNT; e_lock = 0; good = 0; bad_n = 0; end
            end
          end
        end
      endcase
    end
  endtask
  task automatic step(input bit r, input bit wl, input logic [1:0] p);
    srst = r;
    bus.word_locked = wl;
    bus.am_ping = p;
    @(posedge clk);
    ref_step(r, wl, int'(p));
    #1;
    chk("fallback_req", int'(bus.fallback_req), e_fb);
    chk("skew_err", int'(bus.skew_err), e_err);
    chk("deskew_locked", int'(bus.deskew_locked), e_lock);
    chk("fallback_cnt", int'(bus.fallback_cnt), e_cnt);
  endtask
  int dly[2];
  task automatic stream(input int n, input int per, input int noise);
    for (int k = 0; k < n; k++) begin
      logic [1:0] p;
      p = '0;
      for (int i = 0; i < 2; i++)
        if (k >= 5 + dly[i] && (k - 5 - dly[i]) % per == 0) p[i] = 1'b1;
      if (noise != 0 && $urandom_range(noise - 1) == 0) p = p ^ 2'($urandom_range(3));
      step(1'b0, 1'b1, p);
      for (int i = 0; i < 2; i++) if (e_fb[i]) dly[i]++;
    end
  endtask
  task automatic gap(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 2'b00);
  endtask
  task automatic relock();
    for (int k = 0; k < 4; k++) begin
      gap(3);
      step(1'b0, 1'b1, 2'b11);
    end
  endtask
  int errs, fbs, at, drop_at, kept;
  initial begin
    bus.word_locked = 1'b0;
    bus.am_ping = '0;
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    chk("rst_locked", int'(bus.deskew_locked), 0);
    chk("rst_cnt", int'(bus.fallback_cnt), 0);
    dly = '{0, 0};
    stream(5 * 64, 64, 0);
    chk("aligned_lock", int'(bus.deskew_locked), 1);
    chk("aligned_cnt", int'(bus.fallback_cnt), 0);
    step(1'b1, 1'b0, 2'b00);
    gap(3);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b00);
    chk("lead2_nofb_yet", int'(bus.fallback_req), 0);
    step(1'b0, 1'b1, 2'b10);
    chk("lead2_fb", int'(bus.fallback_req), 1);
    step(1'b0, 1'b1, 2'b00);
    chk("lead2_fb_1cyc", int'(bus.fallback_req), 0);
    dly = '{1, 2};
    stream(8 * 40, 40, 0);
    chk("lead2_cnt", int'(bus.fallback_cnt), 2);
    chk("lead2_lock", int'(bus.deskew_locked), 1);
    step(1'b1, 1'b0, 2'b00);
    gap(2);
    step(1'b0, 1'b1, 2'b10);
    errs = 0; fbs = 0; at = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, 2'b00);
      if (bus.skew_err) begin errs++; at = k; end
      if (bus.fallback_req != 0) fbs++;
    end
    chk("skew_err_count", errs, 1);
    chk("skew_err_at", at, 7);
    chk("skew_no_fb", fbs, 0);
    relock();
    chk("hunt_after_skew", int'(bus.deskew_locked), 1);
    errs = 0;
    for (int k = 0; k < 2; k++) begin
      gap(10);
      step(1'b0, 1'b1, 2'b10);
      errs += int'(bus.skew_err);
    end
    gap(10);
    step(1'b0, 1'b1, 2'b11);
    for (int k = 0; k < 2; k++) begin
      gap(10);
      step(1'b0, 1'b1, 2'b10);
      errs += int'(bus.skew_err);
    end
    chk("miss_reset_lock", int'(bus.deskew_locked), 1);
    gap(10);
    step(1'b0, 1'b1, 2'b10);
    errs += int'(bus.skew_err);
    chk("miss_errs", errs, 5);
    chk("miss_unlock", int'(bus.deskew_locked), 0);
    relock();
    errs = 0; at = 0; drop_at = 0;
    for (int k = 1; k <= 200; k++) begin
      step(1'b0, 1'b1, 2'b00);
      if (bus.skew_err) begin errs++; if (at == 0) at = k; end
      if (!bus.deskew_locked && drop_at == 0) drop_at = k;
    end
    chk("wd_errs", errs, 3);
    chk("wd_first", at, TMO);
    chk("wd_drop", drop_at, 3 * TMO);
    relock();
    kept = int'(bus.fallback_cnt);
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b00);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b00);
    step(1'b0, 1'b0, 2'b10);
    chk("wl_drop_lock", int'(bus.deskew_locked), 0);
    chk("wl_drop_fb", int'(bus.fallback_req), 0);
    chk("wl_drop_cnt", int'(bus.fallback_cnt), kept);
    relock();
    step(1'b1, 1'b1, 2'b00);
    chk("srst_lock", int'(bus.deskew_locked), 0);
    chk("srst_cnt", int'(bus.fallback_cnt), 0);
    gap(2);
    for (int k = 0; k < 260; k++) begin
      step(1'b0, 1'b1, 2'b01);
      step(1'b0, 1'b1, 2'b10);
      gap(16);
    end
    chk("fcnt_saturate", int'(bus.fallback_cnt), 255);
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(3) == 0) step(1'b1, 1'b0, 2'b00);
      else for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(1'b0, 1'b0, 2'($urandom_range(3)));
      dly = '{int'($urandom_range(9)), int'($urandom_range(9))};
      stream(int'($urandom_range(200, 600)), int'($urandom_range(30, 64)), ($urandom_range(1) == 0) ? 0 : 40);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
